// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks (uart_rx now, uart_tx later):
//   - OVERSAMPLE     : baud-tick oversampling factor (16x)
//   - DEF_DATA_NBITS : default data bits per frame
//   - DEF_SB_TICKS   : default oversampling ticks per stop period (16 = 1 stop bit)
//   - uart_state_t   : receiver/transmitter FSM state encoding
//   - tick_cnt_width : width of the per-bit tick counter for a given stop length
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE     = 16;
   localparam int DEF_DATA_NBITS = 8;
   localparam int DEF_SB_TICKS   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   // The tick counter is 4 bits for a normal 16-tick bit; it only grows when a
   // stop period longer than one bit (e.g. 32 ticks = 2 stop bits) is requested.
   function automatic int tick_cnt_width(input int sb_ticks);
      return (sb_ticks > OVERSAMPLE) ? $clog2(sb_ticks) : $clog2(OVERSAMPLE);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// -----------------------------------------------------------------------------
// rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset to 1
// so the receiver sees an idle line out of reset and never a false start bit.
// Ports:
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   line    : asynchronous serial input (idle high)
//   line_s  : synchronized copy of line, two clock cycles later
// -----------------------------------------------------------------------------
module rx_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic line,
   output logic line_s
);

   logic meta;

   // NOTE: sequential state is always written with non-blocking assignments so
   // the second flop captures the first flop's old value, giving a true 2-stage chain.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= 1'b1;
         line_s <= 1'b1;
      end else begin
         meta   <= line;
         line_s <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 16x-oversampling UART receiver. The line is synchronized, a start bit is
// confirmed at its middle, each data bit is sampled at mid-bit (LSB first) and
// the stop period is checked at its end sample. Every completed frame, good or
// bad, delivers its data word and a one-cycle done pulse.
// Parameters:
//   DATA_NBITS : data bits per frame
//   SB_TICKS   : oversampling ticks in the stop period (16 = 1 bit, 32 = 2 bits)
// Ports:
//   i_clock       : system clock, rising edge
//   i_reset_n     : asynchronous active-low reset
//   i_tick        : one-cycle strobe at 16x the baud rate
//   i_rx          : asynchronous serial line, idle high
//   o_data        : last received word
//   o_rx_done     : one-cycle pulse when a frame completes
//   o_frame_error : stop bit was sampled low in the last completed frame
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_NBITS = DEF_DATA_NBITS,
   parameter int SB_TICKS   = DEF_SB_TICKS
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_tick,
   input  logic                  i_rx,
   output logic [DATA_NBITS-1:0] o_data,
   output logic                  o_rx_done,
   output logic                  o_frame_error
);

   localparam int S_W = tick_cnt_width(SB_TICKS);
   localparam int N_W = (DATA_NBITS > 1) ? $clog2(DATA_NBITS) : 1;

   // Tick counts at which the FSM acts: middle of the start bit, end of a data
   // bit period (which lands mid-bit because timing starts mid-start-bit), and
   // the end of the stop period.
   localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
   localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICKS - 1);
   localparam logic [N_W-1:0] N_LAST = N_W'(DATA_NBITS - 1);

   logic                  rx_s;
   uart_state_t           state, state_next;
   logic [S_W-1:0]        s, s_next;
   logic [N_W-1:0]        n, n_next;
   logic [DATA_NBITS-1:0] shreg, shreg_next;
   logic [DATA_NBITS-1:0] data_next;
   logic                  done_next;
   logic                  ferr_next;

   rx_sync u_rx_sync (
      .clock   (i_clock),
      .reset_n (i_reset_n),
      .line    (i_rx),
      .line_s  (rx_s)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         s             <= '0;
         n             <= '0;
         shreg         <= '0;
         o_data        <= '0;
         o_rx_done     <= 1'b0;
         o_frame_error <= 1'b0;
      end else begin
         state         <= state_next;
         s             <= s_next;
         n             <= n_next;
         shreg         <= shreg_next;
         o_data        <= data_next;
         o_rx_done     <= done_next;
         o_frame_error <= ferr_next;
      end
   end

   always_comb begin
      // NOTE: every next value defaults to its current value before the case,
      // so no path through the logic leaves one unassigned and no latch is inferred.
      state_next = state;
      s_next     = s;
      n_next     = n;
      shreg_next = shreg;
      data_next  = o_data;
      done_next  = 1'b0;
      ferr_next  = o_frame_error;

      case (state)
         IDLE: begin
            // Start detection is level-based and tick-independent, so a line
            // still low after a bad stop bit re-enters START at once (break).
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end

         START: begin
            if (i_tick) begin
               if (s == S_MID) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     // Line is high again at mid-start: it was a glitch.
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end

         DATA: begin
            if (i_tick) begin
               if (s == S_BIT) begin
                  s_next     = '0;
                  shreg_next = {rx_s, shreg[DATA_NBITS-1:1]};
                  if (n == N_LAST) begin
                     state_next = STOP;
                  end else begin
                     n_next = n + 1'b1;
                  end
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end

         STOP: begin
            if (i_tick) begin
               if (s == S_STOP) begin
                  state_next = IDLE;
                  data_next  = shreg;
                  done_next  = 1'b1;
                  ferr_next  = ~rx_s;
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Two instances share one serial line: dut_a
// with a 16-tick stop period and dut_b with a 32-tick stop period. The line is
// described as a list of tick slots (one slot = 4 clocks, tick on the last).
// The reference model scans that slot list using the frame timing rules
// (start confirmed 8 ticks after the edge, data every 16 ticks, stop after
// SB_TICKS more) and predicts, for each instance, the clock cycle of every
// done pulse with its data and frame-error value. A compare process checks
// both instances' outputs on every cycle against those predictions.
// -----------------------------------------------------------------------------
module tb_uart_rx;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       tick;
   logic       rx;
   logic [7:0] data_a, data_b;
   logic       done_a, done_b;
   logic       ferr_a, ferr_b;

   always #5 clock = ~clock;

   uart_rx #(.DATA_NBITS(8), .SB_TICKS(16)) dut_a (
      .i_clock       (clock),
      .i_reset_n     (reset_n),
      .i_tick        (tick),
      .i_rx          (rx),
      .o_data        (data_a),
      .o_rx_done     (done_a),
      .o_frame_error (ferr_a)
   );

   uart_rx #(.DATA_NBITS(8), .SB_TICKS(32)) dut_b (
      .i_clock       (clock),
      .i_reset_n     (reset_n),
      .i_tick        (tick),
      .i_rx          (rx),
      .o_data        (data_b),
      .o_rx_done     (done_b),
      .o_frame_error (ferr_b)
   );

   typedef struct {
      int         cyc;
      logic [7:0] data;
      bit         ferr;
   } ev_t;

   int   n_checks = 0;
   int   n_errs   = 0;
   int   cyc      = 0;
   int   hist_base = 0;
   bit   chk_en   = 1'b0;
   bit   line_hist[$];
   bit   seg[$];
   ev_t  evq_a[$];
   ev_t  evq_b[$];
   logic [7:0] held_data [2];
   bit         held_ferr [2];
   int         done_cnt  [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- stimulus construction ----------------
   function automatic void add_level(input bit lvl, input int n);
      repeat (n) seg.push_back(lvl);
   endfunction

   // One frame: 16-slot start bit, 8 data bits LSB first, then a stop period
   // of stop_len slots; a bad stop holds the line low for its first half bit.
   function automatic void add_frame(input logic [7:0] d, input int stop_len, input bit stop_low);
      add_level(1'b0, 16);
      for (int i = 0; i < 8; i++) add_level(d[i], 16);
      if (stop_low) begin
         add_level(1'b0, 8);
         add_level(1'b1, stop_len - 8);
      end else begin
         add_level(1'b1, stop_len);
      end
   endfunction

   // ---------------- reference model ----------------
   // Walks the whole line history since reset; only frames whose stop sample
   // falls in the newly appended part (slot >= old_len) are queued.
   function automatic void run_model(input int which, input int sb, input int old_len);
      int         t = 0;
      int         t0;
      int         stop;
      bit         forced = 1'b0;
      bit         found;
      logic [7:0] d;
      ev_t        ev;
      while (1) begin
         if (forced) begin
            t0 = t;
         end else begin
            found = 1'b0;
            t0 = 0;
            for (int k = t; k < line_hist.size() && !found; k++) begin
               if (!line_hist[k]) begin
                  found = 1'b1;
                  t0 = k;
               end
            end
            if (!found) break;
         end
         if (t0 + 7 >= line_hist.size()) break;
         if (line_hist[t0 + 7]) begin
            // Glitch: line high again at mid-start.
            t = t0 + 8;
            forced = 1'b0;
            continue;
         end
         stop = t0 + 7 + 16 * 8 + sb;
         if (stop >= line_hist.size()) break;
         for (int i = 0; i < 8; i++) d[i] = line_hist[t0 + 7 + 16 * (i + 1)];
         ev.cyc  = hist_base + 4 * stop + 3;
         ev.data = d;
         ev.ferr = !line_hist[stop];
         if (stop >= old_len) begin
            if (which == 0) evq_a.push_back(ev);
            else            evq_b.push_back(ev);
         end
         // After a low stop sample the line is still low, so a new start
         // begins on the very next slot.
         forced = ev.ferr;
         t = stop + 1;
      end
   endfunction

   // Entered and left at a falling clock edge with tick low.
   task automatic play();
      int old_len = line_hist.size();
      if (old_len == 0) hist_base = cyc + 1;
      foreach (seg[k]) line_hist.push_back(seg[k]);
      run_model(0, 16, old_len);
      run_model(1, 32, old_len);
      for (int k = 0; k < seg.size(); k++) begin
         rx   = seg[k];
         tick = 1'b0;
         repeat (3) @(negedge clock);
         tick = 1'b1;
         @(negedge clock);
         tick = 1'b0;
      end
      seg.delete();
   endtask

   // ---------------- compare process ----------------
   task automatic compare_one(input int which, input logic done, input logic [7:0] data, input logic ferr);
      bit  exp_done = 1'b0;
      ev_t ev;
      if (!reset_n) begin
         held_data[which] = 8'h00;
         held_ferr[which] = 1'b0;
      end else if (which == 0) begin
         if (evq_a.size() > 0 && evq_a[0].cyc == cyc) begin
            ev = evq_a.pop_front();
            exp_done = 1'b1;
            held_data[0] = ev.data;
            held_ferr[0] = ev.ferr;
         end
      end else begin
         if (evq_b.size() > 0 && evq_b[0].cyc == cyc) begin
            ev = evq_b.pop_front();
            exp_done = 1'b1;
            held_data[1] = ev.data;
            held_ferr[1] = ev.ferr;
         end
      end
      if (done === 1'b1) done_cnt[which]++;
      check($sformatf("done_%0d", which), {31'd0, done}, {31'd0, exp_done});
      check($sformatf("data_%0d", which), {24'd0, data}, {24'd0, held_data[which]});
      check($sformatf("ferr_%0d", which), {31'd0, ferr}, {31'd0, held_ferr[which]});
   endtask

   always @(posedge clock) begin
      cyc = cyc + 1;
      #1;
      if (chk_en) begin
         compare_one(0, done_a, data_a, ferr_a);
         compare_one(1, done_b, data_b, ferr_b);
      end
   end

   // ---------------- scenarios ----------------
   int base_a, base_b;

   initial begin
      reset_n = 1'b0;
      rx      = 1'b1;
      tick    = 1'b0;
      held_data[0] = 8'h00; held_data[1] = 8'h00;
      held_ferr[0] = 1'b0;  held_ferr[1] = 1'b0;
      done_cnt[0]  = 0;     done_cnt[1]  = 0;
      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      check("rst_data_a", {24'd0, data_a}, 32'h0);
      check("rst_done_a", {31'd0, done_a}, 32'h0);
      check("rst_ferr_a", {31'd0, ferr_a}, 32'h0);
      check("rst_data_b", {24'd0, data_b}, 32'h0);
      check("rst_ferr_b", {31'd0, ferr_b}, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      // Good frame 0xA5.
      base_a = done_cnt[0]; base_b = done_cnt[1];
      add_frame(8'hA5, 16, 1'b0);
      add_level(1'b1, 180);
      play();
      check("a5_pulses_a", done_cnt[0] - base_a, 1);
      check("a5_data_a", {24'd0, data_a}, 32'hA5);
      check("a5_ferr_a", {31'd0, ferr_a}, 32'h0);
      check("a5_data_b", {24'd0, data_b}, 32'hA5);

      // Back-to-back 0x00 then 0xFF, no idle gap.
      base_a = done_cnt[0];
      add_frame(8'h00, 16, 1'b0);
      add_frame(8'hFF, 16, 1'b0);
      add_level(1'b1, 180);
      play();
      check("b2b_pulses_a", done_cnt[0] - base_a, 2);
      check("b2b_data_a", {24'd0, data_a}, 32'hFF);
      check("b2b_ferr_a", {31'd0, ferr_a}, 32'h0);

      // 3-tick glitch on an idle line.
      base_a = done_cnt[0]; base_b = done_cnt[1];
      add_level(1'b0, 3);
      add_level(1'b1, 180);
      play();
      check("glitch_pulses_a", done_cnt[0] - base_a, 0);
      check("glitch_pulses_b", done_cnt[1] - base_b, 0);

      // 0x3C with a low stop bit, then good 0x11 clears the error.
      base_a = done_cnt[0];
      add_frame(8'h3C, 16, 1'b1);
      add_level(1'b1, 180);
      play();
      check("ferr_pulses_a", done_cnt[0] - base_a, 1);
      check("ferr_data_a", {24'd0, data_a}, 32'h3C);
      check("ferr_flag_a", {31'd0, ferr_a}, 32'h1);
      add_frame(8'h11, 16, 1'b0);
      add_level(1'b1, 180);
      play();
      check("clr_data_a", {24'd0, data_a}, 32'h11);
      check("clr_ferr_a", {31'd0, ferr_a}, 32'h0);

      // Reset during data bit 4 (slots 80..95) of a 0xF0 frame.
      base_a = done_cnt[0]; base_b = done_cnt[1];
      add_frame(8'hF0, 16, 1'b0);
      while (seg.size() > 88) void'(seg.pop_back());
      play();
      reset_n = 1'b0;
      rx      = 1'b1;
      #1;
      check("mid_rst_data_a", {24'd0, data_a}, 32'h0);
      check("mid_rst_ferr_a", {31'd0, ferr_a}, 32'h0);
      check("mid_rst_data_b", {24'd0, data_b}, 32'h0);
      evq_a.delete();
      evq_b.delete();
      line_hist.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      add_level(1'b1, 20);
      add_frame(8'h5A, 16, 1'b0);
      add_level(1'b1, 180);
      play();
      check("rst_pulses_a", done_cnt[0] - base_a, 1);
      check("rst_pulses_b", done_cnt[1] - base_b, 1);
      check("rst_data_5a_a", {24'd0, data_a}, 32'h5A);
      check("rst_data_5a_b", {24'd0, data_b}, 32'h5A);

      // 1.5-bit stop periods: the 32-tick receiver must still take both frames.
      base_b = done_cnt[1];
      add_frame(8'h96, 24, 1'b0);
      add_frame(8'h69, 24, 1'b0);
      add_level(1'b1, 180);
      play();
      check("sb32_pulses_b", done_cnt[1] - base_b, 2);
      check("sb32_data_b", {24'd0, data_b}, 32'h69);
      check("sb32_ferr_b", {31'd0, ferr_b}, 32'h0);

      // Break: line held low, then released.
      add_level(1'b0, 400);
      play();
      check("brk_data_a", {24'd0, data_a}, 32'h0);
      check("brk_ferr_a", {31'd0, ferr_a}, 32'h1);
      check("brk_data_b", {24'd0, data_b}, 32'h0);
      check("brk_ferr_b", {31'd0, ferr_b}, 32'h1);
      add_level(1'b1, 200);
      play();

      // Randomized frames, stop lengths, bad stops, glitches and gaps.
      for (int f = 0; f < 12; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            add_level(1'b0, $urandom_range(1, 5));
            add_level(1'b1, $urandom_range(8, 20));
         end
         add_frame(8'($urandom), $urandom_range(16, 40), $urandom_range(0, 4) == 0);
         add_level(1'b1, $urandom_range(0, 12));
      end
      add_level(1'b1, 180);
      play();

      check("pending_a", evq_a.size(), 0);
      check("pending_b", evq_b.size(), 0);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
